spi_xip_bridge: RTL and testbench

SPI_XIP_BRIDGE -- requirements
Module: spi_xip_bridge

---
 rtl/spi_xip_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_spi_xip_bridge.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_xip_bridge.sv
// APB-to-SPI execute-in-place bridge: read-only flash window backed by a
// one-word line buffer, plus a small control/status register window.
module spi_xip_bridge #(
    parameter logic [31:0] flash_addr_start = 32'h30000000,
    parameter logic [31:0] flash_addr_end   = 32'h3fffffff,
    parameter logic [31:0] csr_base         = 32'h10002000,
    parameter int          addr_bits        = 24,
    parameter int          ss_num           = 8,
    parameter int          ss_idx           = 0,
    parameter logic [7:0]  div_default      = 8'h00,
    parameter logic [7:0]  cmd_default      = 8'h03
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic              in_pwrite,
    input  logic [31:0]       in_pwdata,
    input  logic [3:0]        in_pstrb,
    output logic              in_pready,
    output logic [31:0]       in_prdata,
    output logic              in_pslverr,
    output logic              spi_sck,
    output logic [ss_num-1:0] spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CS_SETUP  = 3'd1;
    localparam logic [2:0] SHIFT_OUT = 3'd2;
    localparam logic [2:0] SHIFT_IN  = 3'd3;
    localparam logic [2:0] CS_HOLD   = 3'd4;
    localparam logic [2:0] RESP      = 3'd5;

    localparam int         TAG_W    = addr_bits - 2;
    localparam int         SHL      = 32 - addr_bits;
    localparam logic [5:0] OUT_LAST = 6'(addr_bits + 7);
    localparam logic [5:0] IN_LAST  = 6'd31;

    logic [2:0]       state;
    logic [7:0]       div;
    logic [7:0]       cmd;
    logic [7:0]       div_q;
    logic [7:0]       hcnt;
    logic [5:0]       bitcnt;
    logic             sck;
    logic [39:0]      shreg;
    logic [31:0]      rx;
    logic [TAG_W-1:0] tag_q;
    logic             buf_valid;
    logic [TAG_W-1:0] buf_tag;
    logic [31:0]      buf_data;

    logic             access;
    logic             is_flash;
    logic             is_csr;
    logic             is_ctrl;
    logic [2:0]       csr_off;
    logic [TAG_W-1:0] tag_in;
    logic             buf_hit;
    logic             idle;
    logic             err_acc;
    logic             csr_acc;
    logic             hit_acc;
    logic             miss;
    logic             busy;
    logic [31:0]      fa;
    logic [39:0]      sh_load;
    logic [31:0]      rx_le;
    logic [31:0]      ctrl_word;
    logic [31:0]      status_word;
    logic             unused;

    assign unused = ^{in_pwdata[31:16], in_pstrb[3:2]};

    // Flash has decode priority should the two windows ever overlap.
    assign access   = in_psel & in_penable;
    assign is_flash = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
    assign is_csr   = !is_flash && (in_paddr >= csr_base)
                      && (in_paddr <= csr_base + 32'd7);
    assign csr_off  = in_paddr[2:0] - csr_base[2:0];
    assign is_ctrl  = csr_off < 3'd4;
    assign tag_in   = in_paddr[addr_bits-1:2];
    assign buf_hit  = buf_valid && (buf_tag == tag_in);
    assign idle     = state == IDLE;
    assign busy     = !idle;

    assign err_acc = idle && access && ((!is_flash && !is_csr) || (is_flash && in_pwrite));
    assign csr_acc = idle && access && is_csr;
    assign hit_acc = idle && access && is_flash && !in_pwrite && buf_hit;
    assign miss    = idle && access && is_flash && !in_pwrite && !buf_hit;

    always_comb begin
        fa = '0;
        fa[addr_bits-1:2] = in_paddr[addr_bits-1:2];
    end

    // Opcode and word address left-aligned so bit 39 is always next on MOSI.
    assign sh_load = {cmd, fa << SHL};

    // First byte off the wire belongs in the least significant lane.
    assign rx_le       = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    assign ctrl_word   = {16'b0, cmd, div};
    assign status_word = {30'b0, buf_valid, busy};

    assign in_pready  = !reset && (err_acc || csr_acc || hit_acc || state == RESP);
    assign in_pslverr = !reset && err_acc;

    always_comb begin
        in_prdata = '0;
        if (!reset) begin
            if (csr_acc && !in_pwrite) begin
                in_prdata = is_ctrl ? ctrl_word : status_word;
            end else if (hit_acc) begin
                in_prdata = buf_data;
            end else if (state == RESP) begin
                in_prdata = rx_le;
            end
        end
    end

    always_comb begin
        spi_ss = '1;
        if (state == CS_SETUP || state == SHIFT_OUT || state == SHIFT_IN || state == CS_HOLD) begin
            spi_ss[ss_idx] = 1'b0;
        end
    end

    assign spi_sck  = sck;
    assign spi_mosi = (state == SHIFT_OUT) ? shreg[39] : 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            div       <= div_default;
            cmd       <= cmd_default;
            div_q     <= '0;
            hcnt      <= '0;
            bitcnt    <= '0;
            sck       <= 1'b0;
            shreg     <= '0;
            rx        <= '0;
            tag_q     <= '0;
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (csr_acc && in_pwrite && is_ctrl) begin
                        if (in_pstrb[0]) div <= in_pwdata[7:0];
                        if (in_pstrb[1]) cmd <= in_pwdata[15:8];
                        buf_valid <= 1'b0;
                    end
                    if (miss) begin
                        state  <= CS_SETUP;
                        div_q  <= div;
                        shreg  <= sh_load;
                        tag_q  <= tag_in;
                        hcnt   <= '0;
                        bitcnt <= '0;
                        sck    <= 1'b0;
                    end
                end
                CS_SETUP: state <= SHIFT_OUT;
                SHIFT_OUT, SHIFT_IN: begin
                    if (hcnt == div_q) begin
                        hcnt <= '0;
                        sck  <= ~sck;
                        if (!sck && state == SHIFT_IN) begin
                            rx <= {rx[30:0], spi_miso};
                        end
                        // Falling edge closes a bit: advance MOSI and count.
                        if (sck) begin
                            bitcnt <= bitcnt + 6'd1;
                            if (state == SHIFT_OUT) begin
                                shreg <= {shreg[38:0], 1'b0};
                                if (bitcnt == OUT_LAST) begin
                                    state  <= SHIFT_IN;
                                    bitcnt <= '0;
                                end
                            end else if (bitcnt == IN_LAST) begin
                                state <= CS_HOLD;
                            end
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                CS_HOLD: state <= RESP;
                RESP: begin
                    buf_valid <= 1'b1;
                    buf_tag   <= tag_q;
                    buf_data  <= rx_le;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xip_bridge.sv
// Directed bench for spi_xip_bridge: APB master plus a fixed-data SPI
// flash model that also records the command/address it receives.
module tb_spi_xip_bridge;

    localparam logic [31:0] CSR   = 32'h10002000;
    localparam logic [31:0] FWORD = 32'h11223344;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_paddr = '0;
    logic        in_psel = 1'b0;
    logic        in_penable = 1'b0;
    logic        in_pwrite = 1'b0;
    logic [31:0] in_pwdata = '0;
    logic [3:0]  in_pstrb = '0;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic        spi_sck;
    logic [7:0]  spi_ss;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int n_run = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    spi_xip_bridge dut (
        .clock      (clock),
        .reset      (reset),
        .in_paddr   (in_paddr),
        .in_psel    (in_psel),
        .in_penable (in_penable),
        .in_pwrite  (in_pwrite),
        .in_pwdata  (in_pwdata),
        .in_pstrb   (in_pstrb),
        .in_pready  (in_pready),
        .in_prdata  (in_prdata),
        .in_pslverr (in_pslverr),
        .spi_sck    (spi_sck),
        .spi_ss     (spi_ss),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    // Flash model: 32 bits in on rising SCK, then data out on falling SCK.
    int          bitn = 0;
    logic [31:0] mosi_cap = '0;
    int          sck_rises = 0;
    int          ss_lows = 0;

    always @(posedge spi_sck or posedge spi_ss[0]) begin
        if (spi_ss[0]) begin
            bitn = 0;
        end else begin
            if (bitn < 32) mosi_cap = {mosi_cap[30:0], spi_mosi};
            bitn = bitn + 1;
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_ss[0] && bitn >= 32 && bitn < 64) spi_miso = FWORD[63-bitn];
    end

    always @(posedge spi_sck) sck_rises = sck_rises + 1;
    always @(negedge spi_ss[0]) ss_lows = ss_lows + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd,
                       output logic er, output int cyc);
        @(posedge clock);
        #1;
        in_paddr = a; in_pwrite = w; in_pwdata = wd; in_pstrb = st;
        in_psel = 1'b1; in_penable = 1'b0;
        @(posedge clock);
        #1;
        in_penable = 1'b1;
        cyc = 0;
        @(negedge clock);
        while (!in_pready && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        if (!in_pready) check("apb_timeout", {31'b0, in_pready}, 32'd1);
        rd = in_prdata;
        er = in_pslverr;
        @(posedge clock);
        #1;
        in_psel = 1'b0; in_penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        int          r0;
        int          l0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_pready", {31'b0, in_pready}, 32'd0);
        check("rst_ss", {24'b0, spi_ss}, 32'h000000ff);
        check("rst_sck", {31'b0, spi_sck}, 32'd0);
        check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        apb(CSR + 32'd4, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("status_rst", rd, 32'h0);
        apb(CSR, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("ctrl_rst", rd, 32'h00000300);
        check("ctrl_rst_cyc", cyc, 32'd0);

        // Cold miss, div=0
        r0 = sck_rises;
        apb(32'h30000010, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("miss0_cyc", cyc, 32'd131);
        check("miss0_data", rd, 32'h44332211);
        check("miss0_err", {31'b0, er}, 32'd0);
        check("miss0_mosi", mosi_cap, 32'h03000010);
        check("miss0_rises", sck_rises - r0, 32'd64);
        check("idle_mosi", {31'b0, spi_mosi}, 32'd0);
        apb(CSR + 32'd4, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("status_valid", rd, 32'h2);

        // Hit on the same word, different byte offset
        l0 = ss_lows;
        apb(32'h30000012, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("hit_cyc", cyc, 32'd0);
        check("hit_data", rd, 32'h44332211);
        check("hit_no_ss", ss_lows - l0, 32'd0);

        // CTRL write: cmd=0B, div=1; invalidates the buffer
        apb(CSR, 1'b1, 32'h00000b01, 4'b0011, rd, er, cyc);
        check("ctrl_wr_err", {31'b0, er}, 32'd0);
        check("ctrl_wr_cyc", cyc, 32'd0);
        apb(CSR, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("ctrl_rd", rd, 32'h00000b01);
        apb(32'h30000010, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("miss1_cyc", cyc, 32'd259);
        check("miss1_data", rd, 32'h44332211);
        check("miss1_mosi", mosi_cap, 32'h0b000010);

        // Error responses
        r0 = sck_rises;
        apb(32'h30000000, 1'b1, 32'hdeadbeef, 4'hf, rd, er, cyc);
        check("flash_wr_err", {31'b0, er}, 32'd1);
        check("flash_wr_cyc", cyc, 32'd0);
        apb(32'h20000000, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("unmap_err", {31'b0, er}, 32'd1);
        check("unmap_cyc", cyc, 32'd0);
        check("unmap_data", rd, 32'h0);
        check("err_no_sck", sck_rises - r0, 32'd0);

        // Reset in the middle of a miss
        @(posedge clock);
        #1;
        in_paddr = 32'h30000014; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
        @(posedge clock);
        #1 in_penable = 1'b1;
        repeat (50) @(posedge clock);
        #1;
        check("mid_pready", {31'b0, in_pready}, 32'd0);
        check("mid_prdata", in_prdata, 32'h0);
        check("mid_ss", {24'b0, spi_ss}, 32'h000000fe);
        reset = 1'b1; in_psel = 1'b0; in_penable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("mrst_ss", {24'b0, spi_ss}, 32'h000000ff);
        check("mrst_sck", {31'b0, spi_sck}, 32'd0);
        check("mrst_pready", {31'b0, in_pready}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        apb(CSR + 32'd4, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("mrst_status", rd, 32'h0);
        apb(CSR, 1'b0, 32'h0, 4'h0, rd, er, cyc);
        check("mrst_ctrl", rd, 32'h00000300);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
